axis_dsm_dac: RTL
=================

AXIS_DSM_DAC -- requirements
Module: axis_dsm_dac

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of the signed two's-complement sample.
REQ-002 SHALL have parameter OSR, default 64: clock cycles per consumed sample; legal range 2..65535.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port arst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: modulator enable.
REQ-006 SHALL have port s_axis_data_tdata, input, DATA_WIDTH: signed sample.
REQ-007 SHALL have port s_axis_data_tvalid, input, 1: sample valid.
REQ-008 SHALL have port s_axis_data_tready, output, 1: sample accepted when high together with tvalid.
REQ-009 SHALL have port dsm_out, output, 1: registered 1-bit first-order delta-sigma bitstream.
REQ-010 SHALL have port underrun_cnt, output, 16: saturating count of sample ticks that found no buffered data.

Function
REQ-011 SHALL hold accepted samples in a 2-entry FIFO; a transfer occurs on a rising edge with tvalid=1 and tready=1.
REQ-012 SHALL drive s_axis_data_tready = (FIFO occupancy < 2), combinationally from occupancy only; a pop in the same cycle does not raise it.
REQ-013 SHALL accept samples while en=0 until the FIFO is full.
REQ-014 SHALL run tick counter cnt 0..OSR-1, incrementing each cycle while en=1 and wrapping OSR-1 -> 0; "tick" = (en=1 and cnt=OSR-1).
REQ-015 SHALL, on tick with FIFO non-empty, pop the oldest entry into sample register cur, which takes effect from the next cycle.
REQ-016 SHALL, on tick with FIFO empty, keep cur unchanged and increment underrun_cnt, saturating at 65535.
REQ-017 SHALL treat a simultaneous push and tick on an empty FIFO as an underrun; there is no bypass path, and the pushed sample is stored.
REQ-018 SHALL allow a simultaneous push and pop at occupancy 1; occupancy stays 1 and order is preserved.
REQ-019 SHALL form u = cur with the MSB inverted (offset binary, unsigned DATA_WIDTH bits).
REQ-020 SHALL, each cycle with en=1, compute {carry, acc} = acc + u (DATA_WIDTH+1-bit sum), store the low DATA_WIDTH bits in acc, and register carry into dsm_out.
REQ-021 SHALL give a long-run ones density of u / 2^DATA_WIDTH; the accumulator is not cleared on sample change.
REQ-022 SHALL, while en=0, force dsm_out to 0 and hold acc and cnt at 0; cur, the FIFO and underrun_cnt are retained.
REQ-023 SHALL resume on en rising from a state identical to post-reset modulator state (acc=0, cnt=0), so the first tick occurs OSR cycles later.
REQ-024 SHALL contain no combinational path from s_axis_data_tdata or s_axis_data_tvalid to any output.

Reset
REQ-025 SHALL, while arst_n=0, asynchronously clear: FIFO occupancy = 0, cur = 0, acc = 0, cnt = 0, dsm_out = 0, underrun_cnt = 0.
REQ-026 SHALL hold s_axis_data_tready high during and after reset, since the FIFO is empty.
REQ-027 SHALL, on reset asserted mid-operation, discard buffered samples with no further transfers accepted until release.
REQ-028 SHALL, after reset with no data, modulate cur=0, giving a 50% density.

Verification
REQ-029 Reset then en=1, tvalid=0 -> dsm_out = 0,1,0,1,... starting at the first registered cycle; underrun_cnt=1 after OSR cycles and 3 after 3*OSR cycles.
REQ-030 en=0, tvalid=1 held -> exactly 2 transfers, then tready=0 until en=1; tready rises the cycle after the first tick pops an entry.
REQ-031 Sample -32768 loaded -> dsm_out all zeros over the next OSR cycles; sample 16384 -> 48 ones per 64 cycles (OSR=64) once in steady state.
REQ-032 Sample sequence 100, -200, 300 pushed back-to-back -> cur takes 100, -200, 300 on successive ticks, with no underrun increment.
REQ-033 arst_n pulsed low mid-stream with FIFO full -> all REQ-025 values reached immediately and tready=1; the next tick with no push increments underrun_cnt to 1.
REQ-034 Force underrun_cnt to 65535 through sustained starvation (or a reduced-OSR build) -> value stays 65535 on further underruns.

Source files
------------

// File: rtl/axis_dsm_dac.sv
// AXI-Stream fed first-order delta-sigma DAC: a 2-entry sample FIFO drains one
// sample every OSR cycles into an offset-binary accumulator whose carry is the bitstream.
module axis_dsm_dac #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR        = 64
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic                  dsm_out,
  output logic [15:0]           underrun_cnt
);

  localparam int                CNT_W   = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(OSR - 1);

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] fifo_mem_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  // Modulator state
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  dsm_q, dsm_d;
  logic [15:0]           underrun_q, underrun_d;

  logic                  push, pop, tick, underrun;
  logic [DATA_WIDTH-1:0] u;
  logic [DATA_WIDTH:0]   sum;

  // Ready depends on stored occupancy only, so tdata/tvalid never reach an output.
  assign s_axis_data_tready = (occ_q != 2'd2);
  assign push     = s_axis_data_tvalid & s_axis_data_tready;
  assign tick     = en & (cnt_q == CNT_MAX);
  assign pop      = tick & (occ_q != 2'd0);
  assign underrun = tick & (occ_q == 2'd0);

  assign u   = {~cur_q[DATA_WIDTH-1], cur_q[DATA_WIDTH-2:0]};
  assign sum = {1'b0, acc_q} + {1'b0, u};

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    cnt_d      = '0;
    cur_d      = cur_q;
    acc_d      = '0;
    dsm_d      = 1'b0;
    underrun_d = underrun_q;

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      cur_d    = fifo_mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (underrun && (underrun_q != 16'hFFFF)) underrun_d = underrun_q + 16'd1;

    // Disabled: modulator sits in its post-reset state so re-enable is deterministic.
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      acc_d = sum[DATA_WIDTH-1:0];
      dsm_d = sum[DATA_WIDTH];
    end
  end

  // NOTE: sample storage is deliberately left unreset; occupancy guards every read,
  // and leaving it out of the reset tree lets it map onto plain flops or LUT RAM.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= s_axis_data_tdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      cnt_q      <= '0;
      cur_q      <= '0;
      acc_q      <= '0;
      dsm_q      <= 1'b0;
      underrun_q <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      acc_q      <= acc_d;
      dsm_q      <= dsm_d;
      underrun_q <= underrun_d;
    end
  end

  assign dsm_out      = dsm_q;
  assign underrun_cnt = underrun_q;

endmodule
